display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed digit scanner sitting directly upstream of the per-digit seven-segment decoder. Holds an N-digit BCD value, steps a one-hot digit enable at a fixed refresh rate, and drives the current digit's 4-bit nibble to the decoder. New values are accepted through a valid/ready handshake and applied only at a frame boundary, so a frame never mixes old and new digits.

## Interface
- `DIGITS`, 4: number of multiplexed digits, ≥2.
- `TICK_DIV`, 50000: clock cycles per digit slot, ≥2.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `load_valid`  in  1: `load_data` offered.
- `load_ready`  out  1: scanner can accept a value.
- `load_data`  in  4*DIGITS: BCD digits; nibble k = bits [4k+3:4k], digit 0 = least significant.
- `data`  out  4: nibble for the decoder; 4'hF when the digit is blanked.
- `digit_en`  out  DIGITS: one-hot active-high digit select, aligned with `data`.

## Operation
- Prescaler `cnt` counts 0..TICK_DIV-1 and wraps. `tick` = (cnt == TICK_DIV-1).
- Digit index `idx` advances on `tick`, wrapping DIGITS-1 -> 0. Frame boundary = `tick` while idx == DIGITS-1.
- Registers:
  - `disp`: value on display.
  - `pend` plus `pend_full`: one-entry holding buffer.
- `load_ready` = !pend_full, registered.
- Accept = load_valid && load_ready.
- Boundary with pend_full: disp <= pend, pend_full <= 0.
- Boundary without pend_full but with an accept in the same cycle: disp <= load_data directly. pend_full stays 0.
- Accept off-boundary: pend <= load_data, pend_full <= 1.
- `data` = disp nibble[idx]. `digit_en` = 1 << idx.
- Nibble values 10..15 pass through unchanged. The decoder maps them to all segments off.
- load_valid with load_ready low: ignored, no state change. Holding `load_data` stable while waiting is the sender's responsibility.
- Reset values:
  - cnt = 0, idx = 0, disp = 0, pend = 0, pend_full = 0.
  - load_ready = 1, digit_en = 'b1 (digit 0), data = 4'h0.
- Reset asserted mid-frame or with a pending value: all of the above restored on the next edge. The pending value is discarded.

## Timing
- `data` and `digit_en` are registered and change together, one cycle after the `tick` cycle. Each digit is held exactly TICK_DIV cycles.
- A frame lasts DIGITS*TICK_DIV cycles.
- Value accepted in cycle t off-boundary: `load_ready` is low from t+1. The value reaches the outputs one cycle after the next boundary tick. `load_ready` returns high in that same cycle.
- Value accepted on a boundary cycle with nothing pending: shown from the next cycle (new digit 0). `load_ready` stays high.
- Worst-case load-to-display latency: DIGITS*TICK_DIV + 1 cycles.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - A digit k > 0 outputs `data` = 4'hF when disp nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked. Value 0 shows as a single "0".
  - Blanking is evaluated on `disp` with the same registered timing as `data`.
- `LEADING_ZERO_BLANK_EN` not defined: every digit shows its nibble, with leading zeros displayed.

## Structure
- Shared display package holds:
  - `BLANK_NIBBLE` = 4'hF.
  - Default `DIGITS` / `TICK_DIV` constants.
  - `nibble_t` typedef (logic [3:0]).
- One sub-module, `scan_tick_gen`: parameterised prescaler producing the single-cycle `tick`, with synchronous reset.
- Digit index, handshake, holding buffer and output registers stay in `display_scanner`.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4.
- Reset, then idle 40 cycles: digit_en cycles 0001->0010->0100->1000->0001, each held 4 cycles. data = 0 throughout with blanking off. load_ready = 1.
- Load 16'h1234 mid-frame (idx=1): load_ready falls next cycle. After the boundary, digits show 4,3,2,1 for idx 0..3. load_ready rises in the same cycle the new digit 0 appears.
- Load 16'h5678 exactly on a boundary tick with nothing pending: the next cycle shows digit_en 0001, data 8. load_ready never drops.
- Two back-to-back loads, 16'h1111 then 16'h2222 while load_ready is low: the second is ignored. The display shows 1111, and after a later accepted load of 2222, shows 2222.
- With `LEADING_ZERO_BLANK_EN`, load 16'h0050: idx0 = 0, idx1 = 5, idx2 and idx3 = 4'hF. Load 16'h0000: idx0 = 0, others = 4'hF. Without the macro, all shown literally.
- Assert reset for 1 cycle with a value pending mid-frame: next cycle cnt/idx/outputs are at reset values, load_ready = 1, and the pending value never appears.

Source files
------------

// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner_pkg
//  Description : Shared constants and types for the multiplexed display
//                scanner: default geometry, the blank nibble code and the
//                nibble type handed to the seven-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scanner_pkg;

    localparam int DEFAULT_DIGITS   = 4;
    localparam int DEFAULT_TICK_DIV = 50000;

    typedef logic [3:0] nibble_t;

    // Code the decoder renders as all segments off.
    localparam nibble_t BLANK_NIBBLE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/display_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner_if
//  Description : Load handshake plus scan outputs of the display scanner.
//                master : value source / display consumer
//                slave  : display_scanner
//  Signals     : load_valid, load_ready, load_data[4*DIGITS-1:0],
//                data[3:0], digit_en[DIGITS-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scanner_if
    import display_scanner_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) ();

    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_data;
    nibble_t               data;
    logic [DIGITS-1:0]     digit_en;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  data,
        input  digit_en
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output data,
        output digit_en
    );

endinterface
`default_nettype wire

// File: rtl/display_scanner_scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : Free-running prescaler counting 0..TICK_DIV-1; o_tick is
//                high for the single cycle in which the count is at its
//                last value.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset (count to 0)
//                o_tick - one-cycle slot strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen
    import display_scanner_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      o_tick
);

    localparam int                 c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Time-multiplexed BCD digit scanner. Steps a one-hot digit
//                enable every TICK_DIV cycles and presents the selected
//                digit's nibble. New values arrive over a valid/ready
//                handshake and are swapped in only at a frame boundary.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                bus   - display_scanner_if.slave (load handshake, data,
//                        digit_en)
//  Options     : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//                above digit 0 are output as the blank nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  wire logic          clk,
    input  wire logic          reset,
    display_scanner_if.slave   bus
);

    localparam int                 c_idx_w    = $clog2(DIGITS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_boundary;

    logic [c_idx_w-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_disp;
    logic [4*DIGITS-1:0]  r_pend;
    logic                 r_pend_full;
    logic                 r_load_ready;
    nibble_t              r_data;
    logic [DIGITS-1:0]    r_digit_en;

    logic [c_idx_w-1:0]   w_idx_next;
    logic [4*DIGITS-1:0]  w_disp_next;
    logic [4*DIGITS-1:0]  w_pend_next;
    logic                 w_pend_full_next;
    logic [DIGITS-1:0]    w_en_next;
    nibble_t              w_nib_next;
    nibble_t              w_data_next;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (reset),
        .o_tick (w_tick)
    );

    assign w_accept   = bus.load_valid && r_load_ready;
    assign w_boundary = w_tick && (r_idx == c_idx_last);

    // Next-state for index and buffers. The outputs are registered from the
    // *next* display value and index, so a value swapped in at the boundary
    // appears together with the new digit 0.
    always_comb begin
        w_idx_next       = r_idx;
        w_disp_next      = r_disp;
        w_pend_next      = r_pend;
        w_pend_full_next = r_pend_full;

        if (w_tick) begin
            w_idx_next = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end

        // A boundary with a pending value cannot coincide with an accept:
        // load_ready is low whenever the holding buffer is full.
        if (w_boundary && r_pend_full) begin
            w_disp_next      = r_pend;
            w_pend_full_next = 1'b0;
        end else if (w_boundary && w_accept) begin
            w_disp_next = bus.load_data;
        end else if (w_accept) begin
            w_pend_next      = bus.load_data;
            w_pend_full_next = 1'b1;
        end

        w_en_next             = '0;
        w_en_next[w_idx_next] = 1'b1;
        w_nib_next            = w_disp_next[int'(w_idx_next)*4 +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_run;
    logic w_blank;

    // Walk from the top digit down; the selected digit (never digit 0) is
    // blanked while every nibble from it upward is zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            w_zero_run = w_zero_run && (w_disp_next[4*k +: 4] == 4'h0);
            if ((k == int'(w_idx_next)) && w_zero_run) begin
                w_blank = 1'b1;
            end
        end
        w_data_next = w_blank ? BLANK_NIBBLE : w_nib_next;
    end
`else
    assign w_data_next = w_nib_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_load_ready <= 1'b1;
            r_data       <= 4'h0;
            r_digit_en   <= DIGITS'(1);
        end else begin
            r_idx        <= w_idx_next;
            r_disp       <= w_disp_next;
            r_pend       <= w_pend_next;
            r_pend_full  <= w_pend_full_next;
            r_load_ready <= !w_pend_full_next;
            r_data       <= w_data_next;
            r_digit_en   <= w_en_next;
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.data       = r_data;
    assign bus.digit_en   = r_digit_en;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Directed self-checking bench for display_scanner with
//                DIGITS=4, TICK_DIV=4. Position in the frame is tracked by
//                counting clock edges since reset (tcount): slot = tcount/4,
//                the boundary tick cycle is tcount%16 == 15.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   tcount;

    display_scanner_if #(.DIGITS(4)) bus ();

    display_scanner #(
        .DIGITS   (4),
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_en(int t);
        logic [3:0] v;
        v = 4'b0001 << ((t / 4) % 4);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        tcount++;
        #1;
    endtask

    task automatic goto_phase(int p);
        for (int i = 0; i < 16 && (tcount % 16) != p; i++) step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        tcount = 0;
        #1;
        reset = 1'b0;
    endtask

    task automatic load_now(logic [15:0] v);
        bus.load_valid = 1'b1;
        bus.load_data  = v;
        step();
        bus.load_valid = 1'b0;
    endtask

    // Walk one frame from the current boundary and check each digit slot.
    task automatic check_frame(string name, logic [15:0] exp);
        for (int s = 0; s < 4; s++) begin
            goto_phase(4 * s);
            n_checks++;
            if (bus.data !== exp[4*s +: 4] || bus.digit_en !== exp_en(tcount)) begin
                n_fail++;
                $display("FAIL %s slot%0d: data=%h en=%b, expected data=%h en=%b",
                         name, s, bus.data, bus.digit_en, exp[4*s +: 4], exp_en(tcount));
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (bus.digit_en !== 4'b0001 || bus.data !== 4'h0 || bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: en=%b data=%h ready=%b, expected 0001 0 1",
                     bus.digit_en, bus.data, bus.load_ready);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if (bus.digit_en !== exp_en(tcount) || bus.data !== 4'h0 || bus.load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_scan t=%0d: en=%b data=%h ready=%b, expected en=%b data=0 ready=1",
                         tcount, bus.digit_en, bus.data, bus.load_ready, exp_en(tcount));
            end
        end
    endtask

    task automatic test_mid_frame_load();
        goto_phase(5);
        load_now(16'h1234);
        n_checks++;
        if (bus.load_ready !== 1'b0 || bus.data !== 4'h0) begin
            n_fail++;
            $display("FAIL midload_accept: ready=%b data=%h, expected ready=0 data=0",
                     bus.load_ready, bus.data);
        end
        goto_phase(15);
        n_checks++;
        if (bus.load_ready !== 1'b0 || bus.digit_en !== 4'b1000 || bus.data !== 4'h0) begin
            n_fail++;
            $display("FAIL midload_hold: ready=%b en=%b data=%h, expected 0 1000 0",
                     bus.load_ready, bus.digit_en, bus.data);
        end
        goto_phase(0);
        n_checks++;
        if (bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_ready_return: ready=%b, expected 1", bus.load_ready);
        end
        check_frame("midload_frame", 16'h1234);
    endtask

    task automatic test_boundary_load();
        logic [15:0] v;
        v = 16'h5678;
        goto_phase(15);
        n_checks++;
        if (bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_pre_ready: ready=%b, expected 1", bus.load_ready);
        end
        load_now(v);
        n_checks++;
        if (bus.digit_en !== 4'b0001 || bus.data !== 4'h8 || bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_direct: en=%b data=%h ready=%b, expected 0001 8 1",
                     bus.digit_en, bus.data, bus.load_ready);
        end
        for (int i = 1; i < 16; i++) begin
            step();
            n_checks++;
            if (bus.load_ready !== 1'b1 || bus.data !== v[4*((tcount%16)/4) +: 4]) begin
                n_fail++;
                $display("FAIL boundary_frame t=%0d: ready=%b data=%h, expected ready=1 data=%h",
                         tcount, bus.load_ready, bus.data, v[4*((tcount%16)/4) +: 4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        goto_phase(2);
        load_now(16'h1111);
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_accept: ready=%b, expected 0", bus.load_ready);
        end
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h2222;
        step();
        step();
        bus.load_valid = 1'b0;
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_ignored_ready: ready=%b, expected 0", bus.load_ready);
        end
        goto_phase(0);
        check_frame("b2b_first_shown", 16'h1111);
        goto_phase(6);
        load_now(16'h2222);
        goto_phase(0);
        check_frame("b2b_later_load", 16'h2222);
    endtask

    task automatic test_blanking();
        goto_phase(15);
        load_now(16'h0050);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("blank_0050", 16'hFF50);
`else
        check_frame("blank_0050", 16'h0050);
`endif
        goto_phase(15);
        load_now(16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("blank_0000", 16'hFFF0);
`else
        check_frame("blank_0000", 16'h0000);
`endif
        // Inner zero below a nonzero digit is never blanked.
        goto_phase(15);
        load_now(16'h1020);
        check_frame("blank_1020", 16'h1020);
    endtask

    task automatic test_reset_pending();
        goto_phase(6);
        load_now(16'h9999);
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_pending: ready=%b, expected 0", bus.load_ready);
        end
        step();
        step();
        apply_reset();
        n_checks++;
        if (bus.digit_en !== 4'b0001 || bus.data !== 4'h0 || bus.load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstpend_state: en=%b data=%h ready=%b, expected 0001 0 1",
                     bus.digit_en, bus.data, bus.load_ready);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if (bus.digit_en !== exp_en(tcount) || bus.data !== 4'h0 || bus.load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstpend_scan t=%0d: en=%b data=%h ready=%b, expected en=%b data=0 ready=1",
                         tcount, bus.digit_en, bus.data, bus.load_ready, exp_en(tcount));
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        tcount         = 0;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        test_reset();
        test_mid_frame_load();
        test_boundary_load();
        test_back_to_back();
        test_blanking();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
